// File: rtl/restador_pkg.sv
// Shared types and default sizes for the restador subtractor scheduler
// and its helper blocks.
package restador_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam int N_DEF = 8;
  localparam int R_DEF = 4;

endpackage

// File: rtl/restador_scheduler_rr_picker.sv
// Combinational round-robin picker: first set request bit after 'last',
// wrapping modulo R. Kept standalone so other arbiters can reuse it.
module rr_picker #(
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic           valid,
  output logic [IDW-1:0] idx,
  output logic [R-1:0]   onehot
);

  logic [IDW-1:0] cand [R];
  logic [R-1:0]   hit;

  // cand[gi] is the requester examined at scan position gi (gi = 0 is searched first)
  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_cand
      assign cand[gi] = IDW'((32'(last) + 32'(gi) + 32'd1) % 32'(R));
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (hit[i]) begin
        valid = 1'b1;
        idx   = cand[i];
      end
    end
  end

  always_comb begin
    onehot = '0;
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/restador_scheduler.sv
// Shares one registered subtractor among R requesters: round-robin grant,
// operand latch, issue/capture sequencing and a tagged one-cycle result.
module restador_scheduler
  import restador_pkg::*;
#(
  parameter  int N   = N_DEF,
  parameter  int R   = R_DEF,
  localparam int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] a_in,
  input  logic [R*N-1:0] b_in,
  output logic [R-1:0]   gnt,
  output logic [N-1:0]   sub_a,
  output logic [N-1:0]   sub_b,
  input  logic [N-1:0]   sub_y,
  output logic [N-1:0]   y_out,
  output logic [IDW-1:0] y_id,
  output logic           y_borrow,
  output logic           y_valid,
  output logic           busy
);

  logic [N-1:0] a_arr [R];
  logic [N-1:0] b_arr [R];

  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_unpack
      assign a_arr[gi] = a_in[gi*N +: N];
      assign b_arr[gi] = b_in[gi*N +: N];
    end
  endgenerate

  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic [R-1:0]   pick_onehot;

  state_t         state_reg, state_next;
  logic [IDW-1:0] last_reg, last_next;
  logic [IDW-1:0] id_reg, id_next;
  logic [R-1:0]   gnt_reg, gnt_next;
  logic [N-1:0]   sub_a_reg, sub_a_next;
  logic [N-1:0]   sub_b_reg, sub_b_next;
  logic [N-1:0]   y_out_reg, y_out_next;
  logic [IDW-1:0] y_id_reg, y_id_next;
  logic           y_borrow_reg, y_borrow_next;
  logic           y_valid_reg, y_valid_next;
  logic           busy_reg, busy_next;

  rr_picker #(.R(R)) u_picker (
    .req    (req),
    .last   (last_reg),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    id_next       = id_reg;
    gnt_next      = '0;
    sub_a_next    = sub_a_reg;
    sub_b_next    = sub_b_reg;
    y_out_next    = y_out_reg;
    y_id_next     = y_id_reg;
    y_borrow_next = y_borrow_reg;
    y_valid_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        // Operands only change here, so the subtractor inputs are stable while in flight
        if (pick_valid) begin
          gnt_next      = pick_onehot;
          last_next     = pick_idx;
          id_next       = pick_idx;
          sub_a_next    = a_arr[pick_idx];
          sub_b_next    = b_arr[pick_idx];
          y_borrow_next = a_arr[pick_idx] < b_arr[pick_idx];
          state_next    = ISSUE;
        end
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: begin
        y_out_next   = sub_y;
        y_id_next    = id_reg;
        y_valid_next = 1'b1;
        state_next   = RESULT;
      end
      RESULT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      last_reg     <= IDW'(R - 1);
      id_reg       <= '0;
      gnt_reg      <= '0;
      sub_a_reg    <= '0;
      sub_b_reg    <= '0;
      y_out_reg    <= '0;
      y_id_reg     <= '0;
      y_borrow_reg <= 1'b0;
      y_valid_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      id_reg       <= id_next;
      gnt_reg      <= gnt_next;
      sub_a_reg    <= sub_a_next;
      sub_b_reg    <= sub_b_next;
      y_out_reg    <= y_out_next;
      y_id_reg     <= y_id_next;
      y_borrow_reg <= y_borrow_next;
      y_valid_reg  <= y_valid_next;
      busy_reg     <= busy_next;
    end
  end

  assign gnt      = gnt_reg;
  assign sub_a    = sub_a_reg;
  assign sub_b    = sub_b_reg;
  assign y_out    = y_out_reg;
  assign y_id     = y_id_reg;
  assign y_borrow = y_borrow_reg;
  assign y_valid  = y_valid_reg;
  assign busy     = busy_reg;

endmodule
